// File: rtl/button_debouncer_pkg.sv
// Shared types and timing defaults for the push-button debouncer.
package button_debouncer_pkg;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    REL     = 2'd3
  } state_e;

  // Timing defaults for a 12 MHz clock: 10 ms debounce, 1 s long-hold
  localparam int DEF_DEBOUNCE_CYCLES = 120000;
  localparam int DEF_HOLD_CYCLES     = 12000000;

  // Counter width able to hold values up to cycles-1
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and shared
// debounce/hold counter. Produces the clean level plus one-cycle events.
module button_debouncer_channel
  import button_debouncer_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic hold_pulse_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(HOLD_CYCLES - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             p;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             hold_q, hold_d;

  // Two-flop synchronizer, reset to the released pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  // Active-high "pin says pressed" after synchronization
  assign p = sync2_q ^ ACTIVE_LOW;

  // FSM, counter, held flag and registered event strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; strobes are asserted only on the accepting edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    hold_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!p) begin
          // bounce: drop back without any event
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (!held_q) begin
          if (cnt_q == HOLD_PRE) begin
            cnt_d  = HOLD_LAST;
            hold_d = 1'b1;
            held_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      REL: begin
        if (p) begin
          // short release glitch: resume the press; a fired hold stays fired
          state_d = PRESSED;
          cnt_d   = held_q ? HOLD_LAST : '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign pressed_o       = (state_q == PRESSED) || (state_q == REL);
  assign press_pulse_o   = press_q;
  assign release_pulse_o = rel_q;
  assign hold_pulse_o    = hold_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: one independent debounce channel per button pin.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] button,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] hold_pulse
);

  // Pin level that means "released"; each channel normalizes against it
  localparam bit PIN_IDLE = (ACTIVE_LOW != 0);

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    button_debouncer_channel #(
      .ACTIVE_LOW     (PIN_IDLE),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .pin_i          (button[g]),
      .pressed_o      (pressed[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g]),
      .hold_pulse_o   (hold_pulse[g])
    );
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side conditioner for the board push-buttons.
- Turns raw, bouncy, active-low button pins into clean registered levels and single-cycle press, release and long-hold events.
- Sits between the button pins and consumers such as counters and LED logic, so those consumers react to real presses instead of a free-running divided clock.
- One FSM channel per button; all outputs are synchronous to clk.

Parameters:
- N_BUTTONS, 2, number of independent button channels.
- ACTIVE_LOW, 1, 1 = a pin at 0 means pressed; 0 = a pin at 1 means pressed.
- DEBOUNCE_CYCLES, 120000, cycles the input must be stable before a press or release is accepted (10 ms at 12 MHz); must be >= 2.
- HOLD_CYCLES, 12000000, cycles of accepted press before hold_pulse fires (1 s at 12 MHz); must be > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- button  input  N_BUTTONS  raw button pins, asynchronous to clk.
- pressed  output  N_BUTTONS  debounced level per button, 1 = pressed.
- press_pulse  output  N_BUTTONS  one-cycle strobe when a press is accepted.
- release_pulse  output  N_BUTTONS  one-cycle strobe when a release is accepted.
- hold_pulse  output  N_BUTTONS  one-cycle strobe when a press has lasted HOLD_CYCLES.

Behaviour:
- Reset is asynchronous and active-high on rst. While rst=1:
  - pressed, press_pulse, release_pulse and hold_pulse are all 0.
  - Synchronizer flops load the released level (1 if ACTIVE_LOW).
  - Every FSM is in IDLE with its counter at 0.
- Synchronization:
  - Two-flop synchronizer per bit.
  - The second flop's output is normalized to active-high p (XOR with ACTIVE_LOW).
- Each channel has a counter of width clog2(HOLD_CYCLES) and a held flag. States and transitions:
  - IDLE: pressed=0. If p=1, go to ARM and clear the counter.
  - ARM: if p=0, return to IDLE with no pulse (bounce rejected). Otherwise increment the counter. On the edge where the counter is DEBOUNCE_CYCLES-1 and p=1: go to PRESSED, register press_pulse=1 for one cycle, set pressed=1, clear the counter.
  - PRESSED: pressed=1. If p=0, go to REL and clear the counter. Otherwise increment the counter. When it reaches HOLD_CYCLES-1 (counting from press acceptance): register hold_pulse=1 for one cycle, set held=1, and the counter saturates. hold_pulse fires at most once per press; there is no auto-repeat.
  - REL: pressed stays 1. If p=1, return to PRESSED; held is kept, and the counter restarts the hold count only if held=0. If p=0 for DEBOUNCE_CYCLES consecutive cycles: go to IDLE, register release_pulse=1 for one cycle, set pressed=0, clear held.
- Latency (edge 0 = first clk edge that samples the new pin level):
  - press_pulse is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - release_pulse follows the same timing.
- Pulses never overlap within a channel. press_pulse and release_pulse are each preceded by a full stable debounce window.
- Channels are fully independent. Simultaneous events on different buttons produce pulses in the same cycle.
- An input glitch shorter than DEBOUNCE_CYCLES in any state never changes pressed.
- If rst asserts mid-ARM or mid-REL, all outputs go to 0 immediately; no pulse is emitted after rst releases unless a new debounce window completes.
- If the pin is held pressed through reset release, the channel starts in IDLE, so the press is re-debounced and press_pulse fires at DEBOUNCE_CYCLES+3 edges after rst deasserts plus synchronizer fill.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, ARM, PRESSED, REL (2 bits).
  - Default timing constants: DEBOUNCE_CYCLES and HOLD_CYCLES for a 12 MHz clock.
  - Counter width function.
- Sub-module debounce_channel covers one synchronizer, one FSM and one counter for a single button. The top module generates N_BUTTONS instances and handles ACTIVE_LOW normalization.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, ACTIVE_LOW=1.
1. Reset: rst=1 with button=2'b11, then pulse rst to 1 asynchronously mid-cycle -> all outputs 0 immediately; 0 for 10 cycles after release.
2. Clean press: button[0]=0 held for 40 cycles -> press_pulse[0]=1 for exactly one cycle after edge 6; pressed[0]=1 from then on; hold_pulse[0] one cycle, 19 cycles after press_pulse; no second hold_pulse.
3. Bounce: button[0] toggles every 2 cycles for 16 cycles, then returns to 1 -> pressed[0] stays 0 and no pulses on any output.
4. Release with glitch: from the pressed state, button[0]=1 for 2 cycles, 0 for 1 cycle, then 1 steady -> no release_pulse during the glitch; release_pulse[0] once, 6 edges after the final rise; pressed[0]=0.
5. Simultaneous: button=2'b00 on the same edge -> press_pulse=2'b11 in the same cycle; releasing only button[1] later gives release_pulse=2'b10.
6. Reset mid-ARM: press button[0], assert rst at edge 4, release rst at edge 6 with the button still pressed -> no pulse before a fresh full debounce window; press_pulse[0] one cycle once that window completes.
